// File: rtl/fan_temp_controller.sv
// Fan controller: occupancy setpoint with hysteresis, ramp-limited proportional duty,
// period-aligned PWM and a staleness watchdog that forces full speed when samples stop.
module fan_temp_controller #(
    parameter int                 PWM_DIV         = 390,
    parameter logic signed [15:0] T_SET_OCC_Q15   = 16'sd14564,
    parameter logic signed [15:0] T_SET_UNOCC_Q15 = 16'sd16748,
    parameter logic signed [15:0] HYST_Q15        = 16'sd364,
    parameter int                 GAIN_SHIFT      = 3,
    parameter logic [7:0]         DUTY_MIN        = 8'd64,
    parameter logic [7:0]         RAMP_STEP       = 8'd16,
    parameter int                 STALE_TICKS     = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] temp_q15,
    input  logic               temp_vld,
    input  logic               occupied,
    output logic               fan_pwm,
    output logic               fan_on,
    output logic [7:0]         duty,
    output logic [1:0]         state,
    output logic               stale
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON       = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_t;

    localparam int CW = (STALE_TICKS > 1) ? $clog2(STALE_TICKS) : 1;
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_TICKS - 1);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PWM_DIV - 1);

    state_t           r_state;
    logic [7:0]       r_duty;
    logic             r_fan_on;
    logic             r_stale;
    logic [CW-1:0]    r_stale_cnt;
    logic [PW-1:0]    r_pre;
    logic [7:0]       r_step;
    logic [7:0]       r_latch;
    logic             r_pwm;

    logic signed [15:0] w_sp;
    logic signed [16:0] w_temp17;
    logic signed [16:0] w_sp17;
    logic signed [16:0] w_err;
    logic signed [16:0] w_hi;
    logic signed [16:0] w_lo;
    logic [16:0]        w_err_pos;
    logic [17:0]        w_tgt_wide;
    logic [7:0]         w_tgt;
    logic [7:0]         w_ramp;
    logic               w_period_start;
    logic [7:0]         w_latch_nxt;

    // All setpoint arithmetic is widened to 17 bits so extreme codes cannot wrap.
    assign w_sp       = occupied ? T_SET_OCC_Q15 : T_SET_UNOCC_Q15;
    assign w_temp17   = {temp_q15[15], temp_q15};
    assign w_sp17     = {w_sp[15], w_sp};
    assign w_err      = w_temp17 - w_sp17;
    assign w_hi       = w_sp17 + {HYST_Q15[15], HYST_Q15};
    assign w_lo       = w_sp17 - {HYST_Q15[15], HYST_Q15};
    assign w_err_pos  = w_err[16] ? 17'd0 : w_err;
    assign w_tgt_wide = 18'(w_err_pos >> GAIN_SHIFT) + 18'(DUTY_MIN);
    assign w_tgt      = (w_tgt_wide > 18'd255) ? 8'hFF : w_tgt_wide[7:0];

    always_comb begin
        w_ramp = r_duty;
        if (r_duty < w_tgt) begin
            if ((w_tgt - r_duty) > RAMP_STEP) w_ramp = r_duty + RAMP_STEP;
            else                              w_ramp = w_tgt;
        end else if ((r_duty - w_tgt) > RAMP_STEP) begin
            w_ramp = r_duty - RAMP_STEP;
        end else begin
            w_ramp = w_tgt;
        end
        if (w_ramp < DUTY_MIN) w_ramp = DUTY_MIN;
    end

    // A sample always beats a coincident watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OFF;
            r_duty      <= 8'd0;
            r_fan_on    <= 1'b0;
            r_stale     <= 1'b0;
            r_stale_cnt <= '0;
        end else if (temp_vld) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (w_temp17 >= w_hi) begin
                        r_state  <= ST_ON;
                        r_duty   <= DUTY_MIN;
                        r_fan_on <= 1'b1;
                    end else begin
                        r_state  <= ST_OFF;
                        r_duty   <= 8'd0;
                        r_fan_on <= 1'b0;
                    end
                end
                ST_ON, ST_FAILSAFE: begin
                    if (w_temp17 < w_lo) begin
                        r_state  <= ST_OFF;
                        r_duty   <= 8'd0;
                        r_fan_on <= 1'b0;
                    end else begin
                        r_state  <= ST_ON;
                        r_duty   <= w_ramp;
                        r_fan_on <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_OFF;
                    r_duty   <= 8'd0;
                    r_fan_on <= 1'b0;
                end
            endcase
        end else if (r_stale_cnt != STALE_MAX) begin
            r_stale_cnt <= r_stale_cnt + CW'(1);
        end else if (r_state != ST_FAILSAFE) begin
            r_state  <= ST_FAILSAFE;
            r_duty   <= 8'hFF;
            r_fan_on <= 1'b1;
            r_stale  <= 1'b1;
        end
    end

    // Duty is only picked up at the start of a period so no period is cut short or stretched.
    assign w_period_start = (r_pre == '0) && (r_step == 8'd0);
    assign w_latch_nxt    = w_period_start ? r_duty : r_latch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_step  <= 8'd0;
            r_latch <= 8'd0;
            r_pwm   <= 1'b0;
        end else begin
            r_latch <= w_latch_nxt;
            r_pwm   <= (w_latch_nxt == 8'hFF) ? 1'b1 : (r_step < w_latch_nxt);
            if (r_pre == PRE_MAX) begin
                r_pre  <= '0;
                r_step <= r_step + 8'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign fan_pwm = r_pwm;
    assign fan_on  = r_fan_on;
    assign duty    = r_duty;
    assign state   = r_state;
    assign stale   = r_stale;

endmodule

// File: tb/tb_fan_temp_controller.sv
// Directed bench for fan_temp_controller: samples push expected {state,duty,fan_on,stale}
// into a queue that a negedge monitor pops one cycle after each temp_vld.
module tb_fan_temp_controller;

    localparam int PWM_DIV     = 2;
    localparam int STALE_TICKS = 100;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] temp_q15 = 16'sd0;
    logic               temp_vld = 1'b0;
    logic               occupied = 1'b0;
    logic               fan_pwm;
    logic               fan_on;
    logic [7:0]         duty;
    logic [1:0]         state;
    logic               stale;

    always #5 clk = ~clk;

    fan_temp_controller #(
        .PWM_DIV    (PWM_DIV),
        .STALE_TICKS(STALE_TICKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .temp_q15(temp_q15),
        .temp_vld(temp_vld),
        .occupied(occupied),
        .fan_pwm (fan_pwm),
        .fan_on  (fan_on),
        .duty    (duty),
        .state   (state),
        .stale   (stale)
    );

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    int          sample_id = 0;
    logic        vld_seen = 1'b0;
    logic [11:0] m_act;
    logic [11:0] m_exp;

    always @(posedge clk) vld_seen <= temp_vld;

    always @(negedge clk) begin
        if (vld_seen) begin
            m_act = {state, duty, fan_on, stale};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample%0d: unexpected output got %h want none", sample_id, m_act);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp)
                    begin
                        errors++;
                        $display("FAIL sample%0d: state/duty/fan_on/stale got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                 sample_id, m_act[11:10], m_act[9:2], m_act[1], m_act[0],
                                 m_exp[11:10], m_exp[9:2], m_exp[1], m_exp[0]);
                    end
            end
            sample_id++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sample(input logic signed [15:0] t, input logic occ,
                               input logic [1:0] es, input logic [7:0] ed);
        exp_q.push_back({es, ed, (es != 2'd0), 1'b0});
        @(negedge clk);
        temp_q15 = t;
        occupied = occ;
        temp_vld = 1'b1;
        @(negedge clk);
        temp_vld = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (fan_pwm === 1'b1) hi++;
        end
    endtask

    logic               keep_en = 1'b0;
    logic signed [15:0] keep_temp = 16'sd0;
    logic [1:0]         keep_state = 2'd0;
    logic [7:0]         keep_duty = 8'd0;

    // Keeps samples flowing during long PWM measurements so the watchdog stays quiet.
    initial begin
        forever begin
            @(negedge clk);
            if (keep_en) begin
                send_sample(keep_temp, 1'b1, keep_state, keep_duty);
                gap(30);
            end
        end
    end

    // Length of the next complete high run; optionally retargets the keeper at its first cycle.
    task automatic high_run(input logic do_change, input logic signed [15:0] nt,
                            input logic [7:0] nd, output int len);
        int guard;
        guard = 0;
        len   = 0;
        @(negedge clk);
        while (fan_pwm === 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        while (fan_pwm !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        if (do_change) begin
            keep_temp = nt;
            keep_duty = nd;
        end
        while (fan_pwm === 1'b1 && guard < 4000) begin len++; @(negedge clk); guard++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int len;

        // Reset values, then the watchdog with no samples at all.
        rst = 1'b1;
        gap(5);
        check("reset_state", state, 0);
        check("reset_duty", duty, 0);
        check("reset_pwm", fan_pwm, 0);
        check("reset_fan_on", fan_on, 0);
        check("reset_stale", stale, 0);
        rst = 1'b0;
        gap(99);
        check("pre_expiry_state", state, 0);
        gap(1);
        check("failsafe_state", state, 2);
        check("failsafe_duty", duty, 255);
        check("failsafe_stale", stale, 1);
        check("failsafe_fan_on", fan_on, 1);
        gap(600);
        count_high(512, hi);
        check("pwm_duty255_highs", hi, 512);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd239);
        gap(3);

        // Reset in the middle of a period.
        rst = 1'b1;
        gap(1);
        check("midrst_pwm", fan_pwm, 0);
        check("midrst_state", state, 0);
        check("midrst_duty", duty, 0);
        check("midrst_stale", stale, 0);
        gap(3);
        rst = 1'b0;

        // Turn-on and ramp up to target 109.
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd64);  gap(20);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd80);  gap(20);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd96);  gap(20);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd109); gap(20);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd109); gap(20);
        send_sample(16'sd14928, 1'b1, 2'd1, 8'd109); gap(20);

        // Ramp down to the DUTY_MIN floor.
        send_sample(16'sd14400, 1'b1, 2'd1, 8'd93);  gap(20);
        send_sample(16'sd14400, 1'b1, 2'd1, 8'd77);  gap(20);
        send_sample(16'sd14400, 1'b1, 2'd1, 8'd64);  gap(20);
        send_sample(16'sd14400, 1'b1, 2'd1, 8'd64);

        // PWM at duty 64, then a mid-period change to 80.
        keep_temp  = 16'sd14400;
        keep_state = 2'd1;
        keep_duty  = 8'd64;
        keep_en    = 1'b1;
        gap(600);
        count_high(512, hi);
        check("pwm_duty64_highs", hi, 128);
        high_run(1'b1, 16'sd14692, 8'd80, len);
        check("pwm_run_during_change", len, 128);
        high_run(1'b0, 16'sd0, 8'd0, len);
        check("pwm_run_after_change", len, 160);
        keep_en = 1'b0;
        gap(40);

        // Below lo: straight to OFF.
        send_sample(16'sd14199, 1'b1, 2'd0, 8'd0);
        keep_temp  = 16'sd14199;
        keep_state = 2'd0;
        keep_duty  = 8'd0;
        keep_en    = 1'b1;
        gap(600);
        count_high(512, hi);
        check("pwm_duty0_highs", hi, 0);
        keep_en = 1'b0;
        gap(40);

        // Occupancy only takes effect on the next sample.
        send_sample(16'sd15000, 1'b0, 2'd0, 8'd0);
        gap(20);
        occupied = 1'b1;
        gap(5);
        check("occ_no_pulse_state", state, 0);
        send_sample(16'sd15000, 1'b1, 2'd1, 8'd64);

        // Sample lands exactly on the expiry cycle.
        gap(98);
        send_sample(16'sd15000, 1'b1, 2'd1, 8'd80);
        gap(5);
        check("coincide_stale", stale, 0);
        check("coincide_state", state, 1);

        // Extreme codes.
        gap(20);
        send_sample(16'sd32767, 1'b0, 2'd1, 8'd96);
        send_sample(-16'sd32768, 1'b0, 2'd0, 8'd0);
        send_sample(-16'sd32768, 1'b1, 2'd0, 8'd0);
        send_sample(16'sd32767, 1'b1, 2'd1, 8'd64);

        // Back-to-back pulses each advance the ramp.
        exp_q.push_back({2'd1, 8'd80, 1'b1, 1'b0});
        exp_q.push_back({2'd1, 8'd96, 1'b1, 1'b0});
        @(negedge clk);
        temp_q15 = 16'sd14928;
        occupied = 1'b1;
        temp_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        temp_vld = 1'b0;

        gap(10);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
